// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   seg_t           : active-low segment vector {g,f,e,d,c,b,a}
//   SEG_OFF, AN_OFF : all-dark segment / anode patterns
//   HEX_SEG_TABLE   : hex digit 0..F to active-low segment pattern
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Packed so that HEX_SEG_TABLE[v] selects the pattern for digit v
  // (entry 0 is the rightmost field).
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seven_seg_scan_driver_hex_to_seg.sv
// hex_to_seg: combinational hex digit to active-low 7-segment decode.
//   hex : 4-bit digit value
//   seg : segment pattern {g,f,e,d,c,b,a}, active-low
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: drives a 4-digit common-anode 7-segment display
// from an externally generated digit-select code. New data is staged in a
// pending buffer and committed only at the 3->0 frame boundary, and all
// anodes are held dark for BLANK_CYCLES clocks after each select change.
//
// Ports:
//   CLK      system clock
//   RST      synchronous active-high reset
//   SEL      digit-select code from the scan counter
//   LOAD     single-cycle strobe capturing DATA/DP_IN into the pending buffer
//   DATA     four hex digits, digit i = DATA[4i+3:4i], digit 0 rightmost
//   DP_IN    per-digit decimal point request, 1 = lit
//   PENDING  pending buffer not yet committed
//   AN       anode strobes, active-low
//   SEG      segments {g,f,e,d,c,b,a}, active-low
//   DP       decimal point, active-low
//
// Build option: define SEVEN_SEG_LZ_SUPPRESS_EN to blank leading zeros on
// digits 3..1 (digit 0 is always shown).
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 2   // 0..15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  SEL,
  input  logic        LOAD,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP_IN,
  output logic        PENDING,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYCLES);

  logic [1:0]  sel_reg;
  logic [3:0]  blank_cnt_reg, blank_cnt_next;
  logic [15:0] pend_data_reg, pend_data_next;
  logic [3:0]  pend_dp_reg, pend_dp_next;
  logic [15:0] disp_data_reg, disp_data_next;
  logic [3:0]  disp_dp_reg, disp_dp_next;
  logic        pending_reg, pending_next;
  logic [3:0]  an_reg, an_next;
  seg_t        seg_reg, seg_next;
  logic        dp_reg, dp_next;

  logic        sel_change;
  logic        commit;
  logic [1:0]  sel_next;
  logic [3:0]  digit_nibble;
  seg_t        dec_seg;
  logic        lz_blank;

  always_comb begin
    sel_change = (SEL != sel_reg);
    // Only a 3->0 step is a frame boundary; other jumps just re-blank.
    commit     = (sel_reg == 2'd3) && (SEL == 2'd0) && pending_reg;
    // After this edge sel_reg always equals SEL.
    sel_next   = SEL;

    disp_data_next = commit ? pend_data_reg : disp_data_reg;
    disp_dp_next   = commit ? pend_dp_reg   : disp_dp_reg;

    // A load on the boundary edge lands after the commit above, so the old
    // pending value is shown and the new one waits for the next frame.
    pend_data_next = LOAD ? DATA  : pend_data_reg;
    pend_dp_next   = LOAD ? DP_IN : pend_dp_reg;
    pending_next   = LOAD ? 1'b1 : (commit ? 1'b0 : pending_reg);

    if (sel_change)
      blank_cnt_next = BLANK_INIT;
    else if (blank_cnt_reg != 4'd0)
      blank_cnt_next = blank_cnt_reg - 4'd1;
    else
      blank_cnt_next = 4'd0;
  end

  // Decode looks at the post-update select and display buffer so a commit
  // or a select change is reflected on the same edge it happens.
  assign digit_nibble = disp_data_next[{sel_next, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex (digit_nibble),
    .seg (dec_seg)
  );

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
  // upper_zero[i]: display digits i..3 are all zero.
  logic [3:0] upper_zero;
  for (genvar gi = 0; gi < 4; gi++) begin : g_upper_zero
    assign upper_zero[gi] = ~|disp_data_next[15:4*gi];
  end
  assign lz_blank = (sel_next != 2'd0) && upper_zero[sel_next];
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    // A change edge loads BLANK_INIT, so a nonzero count already covers
    // the "change with blanking enabled" case.
    if (blank_cnt_next == 4'd0) begin
      an_next  = ~(4'b0001 << sel_next);
      seg_next = lz_blank ? SEG_OFF : dec_seg;
      dp_next  = ~disp_dp_next[sel_next];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_reg       <= 2'd0;
      blank_cnt_reg <= BLANK_INIT;
      pend_data_reg <= '0;
      pend_dp_reg   <= '0;
      disp_data_reg <= '0;
      disp_dp_reg   <= '0;
      pending_reg   <= 1'b0;
      an_reg        <= AN_OFF;
      seg_reg       <= SEG_OFF;
      dp_reg        <= 1'b1;
    end else begin
      sel_reg       <= sel_next;
      blank_cnt_reg <= blank_cnt_next;
      pend_data_reg <= pend_data_next;
      pend_dp_reg   <= pend_dp_next;
      disp_data_reg <= disp_data_next;
      disp_dp_reg   <= disp_dp_next;
      pending_reg   <= pending_next;
      an_reg        <= an_next;
      seg_reg       <= seg_next;
      dp_reg        <= dp_next;
    end
  end

  assign PENDING = pending_reg;
  assign AN      = an_reg;
  assign SEG     = seg_reg;
  assign DP      = dp_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (BLANK_CYCLES = 2).
// Directed vector table with hand-derived expectations, a few multi-cycle
// sequences, then randomized stimulus against a frame-level reference model.
module tb_seven_seg_scan_driver;

  localparam int B = 2;
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
  localparam logic [6:0] LZ_ZERO = 7'h7F;
`else
  localparam logic [6:0] LZ_ZERO = 7'h40;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  SEL;
  logic        LOAD;
  logic [15:0] DATA;
  logic [3:0]  DP_IN;
  logic        PENDING;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  always #5 CLK = ~CLK;

  seven_seg_scan_driver #(.BLANK_CYCLES(B)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SEL     (SEL),
    .LOAD    (LOAD),
    .DATA    (DATA),
    .DP_IN   (DP_IN),
    .PENDING (PENDING),
    .AN      (AN),
    .SEG     (SEG),
    .DP      (DP)
  );

  int checks = 0;
  int errors = 0;

  // Reference segment patterns, active-low gfedcba.
  logic [6:0] hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: which digit is selected, how long since it last
  // changed, and the shown/pending frames as nibble arrays.
  int         m_digit;
  int         m_since;
  logic       m_pending;
  logic [3:0] m_disp [4];
  logic       m_ddp  [4];
  logic [3:0] m_pbuf [4];
  logic       m_pdp  [4];

  task automatic model_edge();
    if (RST) begin
      m_digit = 0;
      m_since = 0;
      m_pending = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_disp[i] = 4'h0; m_ddp[i] = 1'b0; m_pbuf[i] = 4'h0; m_pdp[i] = 1'b0;
      end
    end else begin
      if (m_digit == 3 && SEL == 2'd0 && m_pending) begin
        m_disp = m_pbuf;
        m_ddp  = m_pdp;
        m_pending = 1'b0;
      end
      if (LOAD) begin
        for (int i = 0; i < 4; i++) begin
          m_pbuf[i] = DATA[4*i +: 4];
          m_pdp[i]  = DP_IN[i];
        end
        m_pending = 1'b1;
      end
      if (int'(SEL) != m_digit) begin
        m_digit = int'(SEL);
        m_since = 0;
      end else if (m_since < 1000) begin
        m_since++;
      end
    end
  endtask

  task automatic model_out(output logic [3:0] an, output logic [6:0] seg,
                           output logic dp, output logic pend);
    logic [3:0] one;
    logic       all_zero;
    one  = 4'b0001;
    pend = m_pending;
    an   = 4'hF;
    seg  = 7'h7F;
    dp   = 1'b1;
    if (m_since >= B) begin
      an  = ~(one << m_digit);
      seg = hex_ref[m_disp[m_digit]];
      dp  = ~m_ddp[m_digit];
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
      all_zero = 1'b1;
      for (int j = m_digit; j < 4; j++)
        if (m_disp[j] != 4'h0) all_zero = 1'b0;
      if (m_digit > 0 && all_zero) seg = 7'h7F;
`else
      all_zero = 1'b0;
`endif
    end
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_pend;
    model_out(e_an, e_seg, e_dp, e_pend);
    check({tag, ".an"},   {12'h0, AN},      {12'h0, e_an});
    check({tag, ".seg"},  {9'h0, SEG},      {9'h0, e_seg});
    check({tag, ".dp"},   {15'h0, DP},      {15'h0, e_dp});
    check({tag, ".pend"}, {15'h0, PENDING}, {15'h0, e_pend});
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pend;
  } vec_t;

  function automatic vec_t v(input logic [1:0] s, input logic ld, input logic [15:0] d,
                             input logic [3:0] dpi, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp, input logic pend);
    vec_t r;
    r.sel = s; r.load = ld; r.data = d; r.dp_in = dpi;
    r.an = an; r.seg = seg; r.dp = dp; r.pend = pend;
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    int lit_cnt;

    // Row = inputs applied at an edge, outputs expected just after it.
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hE, 7'h40, 1, 0));
    vecs.push_back(v(0, 1, 16'h12AF, 4'h1, 4'hE, 7'h40, 1, 1));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hD, LZ_ZERO, 1, 1));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'h7, LZ_ZERO, 1, 1));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hE, 7'h0E, 0, 0));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hD, 7'h08, 1, 0));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hB, 7'h24, 1, 0));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'h7, 7'h79, 1, 0));
    vecs.push_back(v(3, 1, 16'h1111, 4'h0, 4'h7, 7'h79, 1, 1));
    vecs.push_back(v(3, 1, 16'h2222, 4'h0, 4'h7, 7'h79, 1, 1));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hE, 7'h24, 1, 0));
    vecs.push_back(v(0, 1, 16'h3333, 4'h0, 4'hE, 7'h24, 1, 1));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(0, 1, 16'h4444, 4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hE, 7'h30, 1, 1));
    vecs.push_back(v(1, 1, 16'h0050, 4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hD, 7'h30, 1, 1));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hB, 7'h30, 1, 1));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'h7, 7'h30, 1, 1));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(0, 0, 16'h0,    4'h0, 4'hE, 7'h40, 1, 0));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(1, 0, 16'h0,    4'h0, 4'hD, 7'h12, 1, 0));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(2, 0, 16'h0,    4'h0, 4'hB, LZ_ZERO, 1, 0));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(v(3, 0, 16'h0,    4'h0, 4'h7, LZ_ZERO, 1, 0));

    // Reset
    RST = 1'b1; SEL = 2'd0; LOAD = 1'b0; DATA = 16'h0; DP_IN = 4'h0;
    tick();
    tick();
    check("reset.an",   {12'h0, AN},      16'h000F);
    check("reset.seg",  {9'h0, SEG},      16'h007F);
    check("reset.dp",   {15'h0, DP},      16'h0001);
    check("reset.pend", {15'h0, PENDING}, 16'h0000);
    $display("reset: an=%h seg=%h dp=%b pend=%b", AN, SEG, DP, PENDING);
    RST = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      SEL = vecs[i].sel; LOAD = vecs[i].load; DATA = vecs[i].data; DP_IN = vecs[i].dp_in;
      tick();
      $display("vec %0d: sel=%0d load=%0b data=%h -> an=%h seg=%h dp=%b pend=%b",
               i, SEL, LOAD, DATA, AN, SEG, DP, PENDING);
      check($sformatf("vec%0d.an", i),   {12'h0, AN},      {12'h0, vecs[i].an});
      check($sformatf("vec%0d.seg", i),  {9'h0, SEG},      {9'h0, vecs[i].seg});
      check($sformatf("vec%0d.dp", i),   {15'h0, DP},      {15'h0, vecs[i].dp});
      check($sformatf("vec%0d.pend", i), {15'h0, PENDING}, {15'h0, vecs[i].pend});
    end
    LOAD = 1'b0;

    // Reset while pending discards the pending frame and clears the display.
    SEL = 2'd1; LOAD = 1'b1; DATA = 16'hABCD; DP_IN = 4'hF;
    tick();
    check("rstpend.pend_set", {15'h0, PENDING}, 16'h0001);
    LOAD = 1'b0; RST = 1'b1;
    tick();
    check("rstpend.pend_clr", {15'h0, PENDING}, 16'h0000);
    check("rstpend.an",       {12'h0, AN},      16'h000F);
    RST = 1'b0; SEL = 2'd0;
    tick();
    check("rstpend.dark", {12'h0, AN}, 16'h000F);
    tick();
    check("rstpend.an0",  {12'h0, AN},  16'h000E);
    check("rstpend.seg0", {9'h0, SEG},  16'h0040);
    for (int s = 1; s <= 4; s++) begin
      SEL = 2'(s % 4);
      for (int c = 0; c < 3; c++) begin
        tick();
        check_model("rstpend.frame");
      end
    end
    check("rstpend.nocommit", {9'h0, SEG}, 16'h0040);
    $display("reset-while-pending: an=%h seg=%h pend=%b", AN, SEG, PENDING);

    // Slow stepping: each digit dark for B cycles, lit for 8-B.
    for (int s = 1; s <= 4; s++) begin
      SEL = 2'(s % 4);
      lit_cnt = 0;
      for (int c = 0; c < 8; c++) begin
        tick();
        check_model("step8");
        if (AN != 4'hF) lit_cnt++;
      end
      check($sformatf("step8.lit_digit%0d", s % 4), 16'(lit_cnt), 16'(8 - B));
      $display("step8: digit=%0d lit_cycles=%0d", s % 4, lit_cnt);
    end

    // Fast toggling: the blank keeps restarting, display stays dark.
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) SEL = SEL ^ 2'd1;
      tick();
      check("toggle.an", {12'h0, AN}, 16'h000F);
    end
    $display("toggle: an=%h after 20 cycles", AN);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r >= 8 && r < 14) SEL = SEL + 2'd1;
      else if (r >= 14) SEL = 2'($urandom_range(0, 3));
      LOAD  = ($urandom_range(0, 9) == 0);
      DATA  = 16'($urandom);
      DP_IN = 4'($urandom);
      RST   = ($urandom_range(0, 599) == 0);
      tick();
      check_model("rand");
      if (LOAD || RST)
        $display("rand %0d: rst=%0b sel=%0d load=%0b data=%h -> an=%h seg=%h pend=%b",
                 c, RST, SEL, LOAD, DATA, AN, SEG, PENDING);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Downstream consumer of the 2-bit dynamic-lighting digit counter. Takes the counter's digit-select code and a 4-digit hex value from the datapath, and produces the anode strobes, segment pattern and decimal point for a 4-digit common-anode 7-segment display. It provides tear-free frame-synchronous data update and anti-ghosting blanking whenever the select code changes.

## Interface
- BLANK_CYCLES, 2: CLK cycles all anodes are held off after every SEL change; range 0–15.
- CLK  in  1  system clock; same clock as the digit counter.
- RST  in  1  synchronous, active-high reset.
- SEL  in  2  digit-select code from the dynamic-lighting counter; advances 0,1,2,3,0,…
- LOAD  in  1  single-cycle strobe; capture DATA/DP_IN into the pending buffer.
- DATA  in  16  four hex digits; digit i = DATA[4i+3:4i]; digit 0 is the rightmost.
- DP_IN  in  4  decimal point request per digit; 1 = lit.
- PENDING  out  1  pending buffer holds data not yet committed to the display.
- AN  out  4  anode strobes, active-low, one-hot-low when lit.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.

## Operation
- Registers: sel_q[1:0], blank_cnt[3:0], pend_data[15:0]/pend_dp[3:0], disp_data[15:0]/disp_dp[3:0], PENDING, and registered AN/SEG/DP.
- Load:
  - LOAD=1 writes DATA/DP_IN into the pending buffer and sets PENDING.
  - LOAD while PENDING=1 overwrites; last load wins.
- Frame boundary: sel_q==3 and SEL==0 on the same edge.
  - At a boundary with PENDING=1: disp <= pend and PENDING <= 0.
  - LOAD on a boundary edge: the old pending value commits first, then the new value is captured and PENDING=1. If PENDING was 0, nothing commits and the new value is captured.
- Change detect: when SEL != sel_q, update sel_q <= SEL and blank_cnt <= BLANK_CYCLES. Otherwise blank_cnt decrements while nonzero.
- Output register, every edge:
  - If blank_cnt != 0 after update, or a change occurs on this edge with BLANK_CYCLES != 0: AN=4'b1111, SEG=7'h7F, DP=1.
  - Otherwise: AN has bit sel_q low; SEG = decode of disp digit sel_q; DP = ~disp_dp[sel_q].
- Hex decode 0–F uses the standard patterns (e.g. 0→7'h40, 8→7'h00, F→7'h0E, active-low gfedcba).
- SEL sequence: any order is accepted; only 3→0 counts as a frame boundary.

## Timing
- Reset values:
  - AN=4'b1111, SEG=7'h7F, DP=1, PENDING=0.
  - disp/pend data and dp = 0.
  - sel_q=0, blank_cnt=BLANK_CYCLES, so the display is dark for BLANK_CYCLES cycles after reset release.
- SEL change seen at edge k:
  - AN is off from edge k through edge k+BLANK_CYCLES−1.
  - The new digit is lit from edge k+BLANK_CYCLES.
  - With BLANK_CYCLES=0, the new digit is lit from edge k, i.e. one cycle of latency from SEL to AN.
- LOAD→PENDING=1: 1 cycle.
- Commit appears on SEG at the first edge after the boundary at which digit 0 is unblanked.
- RST mid-frame or while PENDING: all state returns to reset values; pending data is discarded.
- Changing SEL faster than BLANK_CYCLES keeps restarting the blank; the display stays dark (legal, no error).

## Configuration
- Macro: SEVEN_SEG_LZ_SUPPRESS_EN.
- Defined: digits 3..1 show SEG=7'h7F when that digit and all higher digits of disp_data are zero.
  - AN timing and DP are unaffected.
  - Digit 0 is never suppressed.
- Undefined: all four digits are always decoded, including leading zeros.

## Structure
- Shared package seven_seg_pkg:
  - SEG_OFF=7'h7F and AN_OFF=4'hF constants.
  - seg_t typedef.
  - The 16-entry hex-to-segment constant table.
- Sub-module hex_to_seg: combinational 4-bit → seg_t decode, instantiated once on the digit selected by sel_q.

## Test plan
- Reset with BLANK_CYCLES=2, SEL held 0, disp=0 → AN=1111 for 2 cycles after RST falls, then AN=1110, SEG=7'h40.
- Load: LOAD DATA=16'h12AF with SEL cycling 0..3 mid-frame → PENDING=1. Old digits persist until the 3→0 boundary; then PENDING=0 and digit 0 shows 7'h0E, digit 3 shows 7'h79.
- Back-to-back loads: LOAD 16'h1111 then LOAD 16'h2222 within one frame → only 2222 is committed at the boundary.
- LOAD on the boundary edge while PENDING=1 → old value is displayed and the new value is pending (PENDING stays 1).
- Blanking: BLANK_CYCLES=3, SEL steps every 8 cycles → each digit is dark for exactly 3 cycles and lit for 5. SEL toggling every 2 cycles → AN stays 1111.
- Leading-zero suppression: SEVEN_SEG_LZ_SUPPRESS_EN defined, DATA=16'h0050 → digits 3 and 2 give SEG=7'h7F, digit 1 gives 7'h12, digit 0 gives 7'h40. Macro undefined → digits 3 and 2 give 7'h40.
